database_stage_unpacker: RTL and testbench
==========================================

DATABASE_STAGE_UNPACKER -- requirements
Module: database_stage_unpacker

Interface
REQ-001 SHALL have parameter DATA_WIDTH_12, 12, width of every database word.
REQ-002 SHALL have parameter NUM_CLASSIFIERS_STAGE, 10, classifiers (trees) per stage.
REQ-003 SHALL have parameter NUM_PARAM_PER_CLASSIFIER, 19, words per classifier.
REQ-004 SHALL have parameter NUM_STAGE_THRESHOLD, 3, threshold words trailing each stage.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_valid  input  1  database word present.
REQ-008 SHALL have port i_data  input  DATA_WIDTH_12  database word.
REQ-009 SHALL have port i_end_single_classifier  input  1  producer marks last word of a classifier.
REQ-010 SHALL have port i_end_database  input  1  producer marks last word of the stage.
REQ-011 SHALL have port o_ready  output  1  word accepted when i_valid and o_ready are both high.
REQ-012 SHALL have port o_classifier_valid  output  1  complete classifier record available.
REQ-013 SHALL have port i_classifier_ready  input  1  downstream takes the record.
REQ-014 SHALL have port o_classifier_params  output  NUM_PARAM_PER_CLASSIFIER*DATA_WIDTH_12  record; word k at bits [12k+11:12k].
REQ-015 SHALL have port o_index_tree  output  DATA_WIDTH_12  classifier index of the current record.
REQ-016 SHALL have port o_stage_valid  output  1  stage thresholds available.
REQ-017 SHALL have port i_stage_ready  input  1  downstream takes the thresholds.
REQ-018 SHALL have port o_stage_threshold  output  NUM_STAGE_THRESHOLD*DATA_WIDTH_12  threshold words, word k at [12k+11:12k].
REQ-019 SHALL have port o_error  output  1  sticky framing-error flag.

Function
REQ-020 SHALL implement FSM states COLLECT_PARAMS, PRESENT_CLASSIFIER, COLLECT_THRESHOLD, PRESENT_STAGE.
REQ-021 SHALL drive o_ready high only in COLLECT_PARAMS and COLLECT_THRESHOLD.
REQ-022 SHALL write each accepted word into slot param_index in COLLECT_PARAMS and increment param_index.
REQ-023 SHALL move to PRESENT_CLASSIFIER on the edge accepting word NUM_PARAM_PER_CLASSIFIER-1, so o_classifier_valid rises in the following cycle (1-cycle latency).
REQ-024 SHALL hold o_classifier_valid, o_classifier_params and o_index_tree stable until i_classifier_ready is sampled high.
REQ-025 SHALL, on classifier transfer, go to COLLECT_THRESHOLD if o_index_tree equals NUM_CLASSIFIERS_STAGE-1, else go to COLLECT_PARAMS with o_index_tree incremented and param_index cleared.
REQ-026 SHALL collect NUM_STAGE_THRESHOLD words in COLLECT_THRESHOLD, then enter PRESENT_STAGE with o_stage_valid high in the following cycle.
REQ-027 SHALL hold o_stage_valid and o_stage_threshold until i_stage_ready is sampled high, then return to COLLECT_PARAMS with o_index_tree and all indices cleared (wrap to next stage).
REQ-028 SHALL ignore i_valid and i_data whenever o_ready is low.
REQ-029 SHALL accept a ready already high in the first valid cycle (zero-wait transfer, one cycle in PRESENT state).

Reset
REQ-030 SHALL on reset assertion immediately enter COLLECT_PARAMS, clear param_index, threshold index and o_index_tree to 0, and drive o_classifier_valid, o_stage_valid, o_error to 0.
REQ-031 SHALL clear o_classifier_params and o_stage_threshold to 0 on reset.
REQ-032 SHALL discard any partially collected record when reset asserts mid-operation.

Configuration
REQ-033 SHALL, with DATABASE_STAGE_UNPACKER_CHECK_EN defined, set o_error on any accepted word where i_end_single_classifier differs from (last parameter word of a classifier) or i_end_database differs from (last threshold word), o_error holding until reset; data flow is unaffected.
REQ-034 SHALL, without DATABASE_STAGE_UNPACKER_CHECK_EN, tie o_error to 0 and leave both end flags unused.

Structure
REQ-035 SHALL take NUM_CLASSIFIERS_STAGE, NUM_PARAM_PER_CLASSIFIER, NUM_STAGE_THRESHOLD defaults and FSM state encoding from shared package database_stage_pkg.
REQ-036 SHALL instantiate the existing counter module for the tree index (max_size NUM_CLASSIFIERS_STAGE-1); no other sub-module.

Verification
REQ-037 SHALL cover: 19 words 0..18 streamed with ready held high -> o_classifier_valid one cycle after word 18, params word k == k, o_index_tree 0.
REQ-038 SHALL cover: i_classifier_ready low 5 cycles -> valid, params and o_ready=0 held for 5 cycles, word on i_data ignored.
REQ-039 SHALL cover: full stage of 10x19 words + thresholds 100,200,300 -> 10 records with o_index_tree 0..9, then o_stage_threshold = {300,200,100}, then o_index_tree back to 0.
REQ-040 SHALL cover: reset asserted after word 7 of classifier 3 -> outputs zero at once, next word lands in slot 0 of classifier 0.
REQ-041 SHALL cover (macro defined): i_end_single_classifier high on word 5 -> o_error=1 from next cycle until reset; macro undefined -> o_error stays 0.

Source files
------------

// File: rtl/database_stage_pkg.sv
// Shared defaults and FSM state encoding for the database stage unpacker.
package database_stage_pkg;

  localparam int unsigned DEF_DATA_WIDTH               = 12;
  localparam int unsigned DEF_NUM_CLASSIFIERS_STAGE    = 10;
  localparam int unsigned DEF_NUM_PARAM_PER_CLASSIFIER = 19;
  localparam int unsigned DEF_NUM_STAGE_THRESHOLD      = 3;

  typedef enum logic [1:0] {
    COLLECT_PARAMS     = 2'd0,
    PRESENT_CLASSIFIER = 2'd1,
    COLLECT_THRESHOLD  = 2'd2,
    PRESENT_STAGE      = 2'd3
  } state_t;

endpackage

// File: rtl/counter.sv
// Wrapping up-counter with synchronous clear; rolls over to 0 after max_size.
module counter #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned max_size = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == WIDTH'(max_size)) ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/database_stage_unpacker.sv
// Splits a serial database word stream into per-classifier records and stage thresholds.
// Optional framing check on the producer's end flags: DATABASE_STAGE_UNPACKER_CHECK_EN.
module database_stage_unpacker
  import database_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_12            = DEF_DATA_WIDTH,
  parameter int unsigned NUM_CLASSIFIERS_STAGE    = DEF_NUM_CLASSIFIERS_STAGE,
  parameter int unsigned NUM_PARAM_PER_CLASSIFIER = DEF_NUM_PARAM_PER_CLASSIFIER,
  parameter int unsigned NUM_STAGE_THRESHOLD      = DEF_NUM_STAGE_THRESHOLD
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              i_valid,
  input  logic [DATA_WIDTH_12-1:0]                          i_data,
  input  logic                                              i_end_single_classifier,
  input  logic                                              i_end_database,
  output logic                                              o_ready,
  output logic                                              o_classifier_valid,
  input  logic                                              i_classifier_ready,
  output logic [NUM_PARAM_PER_CLASSIFIER*DATA_WIDTH_12-1:0] o_classifier_params,
  output logic [DATA_WIDTH_12-1:0]                          o_index_tree,
  output logic                                              o_stage_valid,
  input  logic                                              i_stage_ready,
  output logic [NUM_STAGE_THRESHOLD*DATA_WIDTH_12-1:0]      o_stage_threshold,
  output logic                                              o_error
);

  localparam int unsigned PIDX_W = $clog2(NUM_PARAM_PER_CLASSIFIER + 1);
  localparam int unsigned TIDX_W = $clog2(NUM_STAGE_THRESHOLD + 1);
  localparam logic [PIDX_W-1:0]        LAST_PARAM = PIDX_W'(NUM_PARAM_PER_CLASSIFIER - 1);
  localparam logic [TIDX_W-1:0]        LAST_THR   = TIDX_W'(NUM_STAGE_THRESHOLD - 1);
  localparam logic [DATA_WIDTH_12-1:0] LAST_TREE  = DATA_WIDTH_12'(NUM_CLASSIFIERS_STAGE - 1);

  state_t              state;
  logic [PIDX_W-1:0]   param_index;
  logic [TIDX_W-1:0]   thr_index;
  logic                accept;
  logic                cls_xfer;
  logic                stage_xfer;
  logic                tree_last;

  assign accept     = i_valid && o_ready;
  assign cls_xfer   = (state == PRESENT_CLASSIFIER) && i_classifier_ready;
  assign stage_xfer = (state == PRESENT_STAGE) && i_stage_ready;
  assign tree_last  = (o_index_tree == LAST_TREE);

  // Tree index advances per delivered record, cleared when the stage is handed off.
  counter #(
    .WIDTH    (DATA_WIDTH_12),
    .max_size (NUM_CLASSIFIERS_STAGE - 1)
  ) u_tree_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (stage_xfer),
    .enable (cls_xfer && !tree_last),
    .count  (o_index_tree)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= COLLECT_PARAMS;
      param_index         <= '0;
      thr_index           <= '0;
      o_ready             <= 1'b1;
      o_classifier_valid  <= 1'b0;
      o_stage_valid       <= 1'b0;
      o_classifier_params <= '0;
      o_stage_threshold   <= '0;
    end else begin
      case (state)
        COLLECT_PARAMS: begin
          if (accept) begin
            for (int k = 0; k < NUM_PARAM_PER_CLASSIFIER; k++) begin
              if (param_index == PIDX_W'(k)) begin
                o_classifier_params[k*DATA_WIDTH_12 +: DATA_WIDTH_12] <= i_data;
              end
            end
            param_index <= param_index + PIDX_W'(1);
            if (param_index == LAST_PARAM) begin
              state              <= PRESENT_CLASSIFIER;
              o_ready            <= 1'b0;
              o_classifier_valid <= 1'b1;
            end
          end
        end
        PRESENT_CLASSIFIER: begin
          if (i_classifier_ready) begin
            param_index        <= '0;
            o_ready            <= 1'b1;
            o_classifier_valid <= 1'b0;
            state              <= tree_last ? COLLECT_THRESHOLD : COLLECT_PARAMS;
          end
        end
        COLLECT_THRESHOLD: begin
          if (accept) begin
            for (int k = 0; k < NUM_STAGE_THRESHOLD; k++) begin
              if (thr_index == TIDX_W'(k)) begin
                o_stage_threshold[k*DATA_WIDTH_12 +: DATA_WIDTH_12] <= i_data;
              end
            end
            thr_index <= thr_index + TIDX_W'(1);
            if (thr_index == LAST_THR) begin
              state         <= PRESENT_STAGE;
              o_ready       <= 1'b0;
              o_stage_valid <= 1'b1;
            end
          end
        end
        PRESENT_STAGE: begin
          if (i_stage_ready) begin
            param_index   <= '0;
            thr_index     <= '0;
            o_ready       <= 1'b1;
            o_stage_valid <= 1'b0;
            state         <= COLLECT_PARAMS;
          end
        end
        default: state <= COLLECT_PARAMS;
      endcase
    end
  end

`ifdef DATABASE_STAGE_UNPACKER_CHECK_EN
  logic exp_end_cls;
  logic exp_end_db;

  assign exp_end_cls = (state == COLLECT_PARAMS) && (param_index == LAST_PARAM);
  assign exp_end_db  = (state == COLLECT_THRESHOLD) && (thr_index == LAST_THR);

  // Sticky: any accepted word whose end flags disagree with its position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_error <= 1'b0;
    end else if (accept && ((i_end_single_classifier != exp_end_cls) ||
                            (i_end_database != exp_end_db))) begin
      o_error <= 1'b1;
    end
  end
`else
  logic unused_end_flags;
  assign unused_end_flags = &{1'b0, i_end_single_classifier, i_end_database};
  assign o_error          = 1'b0;
`endif

endmodule

// File: tb/tb_database_stage_unpacker.sv
// Self-checking bench: directed sequences, a stall table and a randomized run against a word-count model.
module tb_database_stage_unpacker;

  localparam int DW = 12;
  localparam int NC = 10;
  localparam int NP = 19;
  localparam int NT = 3;
`ifdef DATABASE_STAGE_UNPACKER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic               clk;
  logic               reset;
  logic               i_valid;
  logic [DW-1:0]      i_data;
  logic               i_end_single_classifier;
  logic               i_end_database;
  logic               o_ready;
  logic               o_classifier_valid;
  logic               i_classifier_ready;
  logic [NP*DW-1:0]   o_classifier_params;
  logic [DW-1:0]      o_index_tree;
  logic               o_stage_valid;
  logic               i_stage_ready;
  logic [NT*DW-1:0]   o_stage_threshold;
  logic               o_error;

  database_stage_unpacker dut (
    .clk                     (clk),
    .reset                   (reset),
    .i_valid                 (i_valid),
    .i_data                  (i_data),
    .i_end_single_classifier (i_end_single_classifier),
    .i_end_database          (i_end_database),
    .o_ready                 (o_ready),
    .o_classifier_valid      (o_classifier_valid),
    .i_classifier_ready      (i_classifier_ready),
    .o_classifier_params     (o_classifier_params),
    .o_index_tree            (o_index_tree),
    .o_stage_valid           (o_stage_valid),
    .i_stage_ready           (i_stage_ready),
    .o_stage_threshold       (o_stage_threshold),
    .o_error                 (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Reference model: position of the next word inside the stage stream.
  int            stage_pos;
  bit            m_pend_cls;
  bit            m_pend_stg;
  bit            m_err;
  logic [DW-1:0] cur_rec[$];
  logic [DW-1:0] cur_thr[$];
  logic [NP*DW-1:0] m_params;
  logic [NT*DW-1:0] m_thr;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_index();
    if (stage_pos >= NC*NP) return NC-1;
    if (m_pend_cls) return (stage_pos-1)/NP;
    return stage_pos/NP;
  endfunction

  task automatic model_clear();
    stage_pos  = 0;
    m_pend_cls = 1'b0;
    m_pend_stg = 1'b0;
    m_err      = 1'b0;
    cur_rec.delete();
    cur_thr.delete();
  endtask

  // One cycle, entered and left at a falling edge: check outputs, drive inputs, advance model.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit cr, input bit sr,
                      input bit corrupt, output bit acc);
    bit exp_rdy;
    bit last_p;
    bit last_t;
    exp_rdy = !(m_pend_cls || m_pend_stg);
    chk("o_ready", 256'(o_ready), 256'(exp_rdy));
    chk("o_classifier_valid", 256'(o_classifier_valid), 256'(m_pend_cls));
    chk("o_stage_valid", 256'(o_stage_valid), 256'(m_pend_stg));
    chk("o_index_tree", 256'(o_index_tree), 256'(exp_index()));
    chk("o_error", 256'(o_error), 256'(m_err));
    if (m_pend_cls) chk("o_classifier_params", 256'(o_classifier_params), 256'(m_params));
    if (m_pend_stg) chk("o_stage_threshold", 256'(o_stage_threshold), 256'(m_thr));

    last_p = (stage_pos < NC*NP) && (stage_pos % NP == NP-1);
    last_t = (stage_pos == NC*NP + NT - 1);
    i_valid                 = v;
    i_data                  = d;
    i_classifier_ready      = cr;
    i_stage_ready           = sr;
    i_end_single_classifier = last_p ^ corrupt;
    i_end_database          = last_t;

    acc = exp_rdy && v;
    if (acc) begin
      if (corrupt && CHECK_EN) m_err = 1'b1;
      if (stage_pos < NC*NP) begin
        cur_rec.push_back(d);
        if (cur_rec.size() == NP) begin
          for (int k = 0; k < NP; k++) m_params[k*DW +: DW] = cur_rec[k];
          cur_rec.delete();
          m_pend_cls = 1'b1;
        end
      end else begin
        cur_thr.push_back(d);
        if (cur_thr.size() == NT) begin
          for (int k = 0; k < NT; k++) m_thr[k*DW +: DW] = cur_thr[k];
          cur_thr.delete();
          m_pend_stg = 1'b1;
        end
      end
      stage_pos++;
    end else if (m_pend_cls && cr) begin
      m_pend_cls = 1'b0;
    end else if (m_pend_stg && sr) begin
      m_pend_stg = 1'b0;
      stage_pos  = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer one word with both downstream readies high until it is accepted.
  task automatic send(input logic [DW-1:0] d, input bit corrupt);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 8 && !acc; t++) step(1'b1, d, 1'b1, 1'b1, corrupt, acc);
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: word %0h not accepted within 8 cycles", d);
    end
  endtask

  // Assert reset mid-cycle and check the asynchronous clear before any clock edge.
  task automatic do_reset();
    reset                   = 1'b1;
    i_valid                 = 1'b0;
    i_data                  = '0;
    i_classifier_ready      = 1'b0;
    i_stage_ready           = 1'b0;
    i_end_single_classifier = 1'b0;
    i_end_database          = 1'b0;
    #1;
    chk("rst_classifier_valid", 256'(o_classifier_valid), 256'(0));
    chk("rst_stage_valid", 256'(o_stage_valid), 256'(0));
    chk("rst_error", 256'(o_error), 256'(0));
    chk("rst_index_tree", 256'(o_index_tree), 256'(0));
    chk("rst_params", 256'(o_classifier_params), 256'(0));
    chk("rst_threshold", 256'(o_stage_threshold), 256'(0));
    chk("rst_ready", 256'(o_ready), 256'(1));
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit            v;
    logic [DW-1:0] d;
    bit            cr;
    bit            exp_rdy;
    bit            exp_cv;
    logic [DW-1:0] exp_idx;
  } vec_t;

  vec_t tbl[7];
  logic [NP*DW-1:0] e37;
  logic [NT*DW-1:0] e39;
  bit acc;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    do_reset();

    // Words 0..18 with a stalled consumer; record must appear one cycle after word 18.
    for (int k = 0; k < NP; k++) step(1'b1, DW'(k), 1'b0, 1'b0, 1'b0, acc);
    for (int k = 0; k < NP; k++) e37[k*DW +: DW] = DW'(k);
    chk("w18_classifier_valid", 256'(o_classifier_valid), 256'(1));
    chk("w18_params", 256'(o_classifier_params), 256'(e37));
    chk("w18_index_tree", 256'(o_index_tree), 256'(0));

    // Consumer held off five cycles while the producer keeps offering a word.
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 12'hABC, 1'b0, 1'b0, 1'b1, 12'd0};
    tbl[5] = '{1'b1, 12'hABC, 1'b1, 1'b0, 1'b1, 12'd0};
    tbl[6] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'd1};
    for (int i = 0; i < 7; i++) begin
      chk("tbl_ready", 256'(o_ready), 256'(tbl[i].exp_rdy));
      chk("tbl_classifier_valid", 256'(o_classifier_valid), 256'(tbl[i].exp_cv));
      chk("tbl_index_tree", 256'(o_index_tree), 256'(tbl[i].exp_idx));
      if (tbl[i].exp_cv) chk("tbl_params_held", 256'(o_classifier_params), 256'(e37));
      step(tbl[i].v, tbl[i].d, tbl[i].cr, 1'b0, 1'b0, acc);
    end

    // Full stage: ten records then thresholds 100, 200, 300.
    do_reset();
    for (int t = 0; t < NC; t++)
      for (int k = 0; k < NP; k++) send(DW'(t*NP + k + 1), 1'b0);
    send(12'd100, 1'b0);
    send(12'd200, 1'b0);
    send(12'd300, 1'b0);
    e39 = {12'd300, 12'd200, 12'd100};
    chk("stage_valid", 256'(o_stage_valid), 256'(1));
    chk("stage_threshold", 256'(o_stage_threshold), 256'(e39));
    chk("stage_index_tree", 256'(o_index_tree), 256'(NC-1));
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    chk("wrap_index_tree", 256'(o_index_tree), 256'(0));
    chk("wrap_ready", 256'(o_ready), 256'(1));

    // Reset after word 7 of classifier 3; the next record restarts at slot 0 of tree 0.
    do_reset();
    for (int i = 0; i < 3*NP + 8; i++) send(DW'(i + 7), 1'b0);
    do_reset();
    for (int k = 0; k < NP; k++) send(DW'(500 + k), 1'b0);
    chk("post_rst_slot0", 256'(o_classifier_params[DW-1:0]), 256'(500));
    chk("post_rst_index_tree", 256'(o_index_tree), 256'(0));

    // Misplaced end-of-classifier flag on word 5.
    do_reset();
    for (int k = 0; k < 5; k++) send(DW'(k), 1'b0);
    send(12'd5, 1'b1);
    chk("err_after_word5", 256'(o_error), 256'(CHECK_EN));
    for (int k = 6; k < 12; k++) send(DW'(k), 1'b0);
    chk("err_sticky", 256'(o_error), 256'(CHECK_EN));
    do_reset();

    // Randomized traffic with random back-pressure on both outputs.
    for (int c = 0; c < 2000; c++)
      step($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, 1'b0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
